// File: rtl/blackjack_hand_scorer_pkg.sv
// blackjack_pkg: shared state/result encodings, card constants and best-total helper
package blackjack_pkg;
   typedef enum logic [2:0] {IDLE, PLAYER, DEALER, RESOLVE, DONE} state_t;
   typedef enum logic [1:0] {
      RES_NONE   = 2'b00,
      RES_PLAYER = 2'b01,
      RES_DEALER = 2'b10,
      RES_PUSH   = 2'b11
   } result_t;
   localparam logic [3:0] ACE_VALUE = 4'd1;
   localparam logic [3:0] MAX_CARD  = 4'd10;
   localparam logic [4:0] ACE_BONUS = 5'd10;
   // an ace counts 11 whenever that does not push the hand past 21
   function automatic logic [4:0] best_of(input logic [4:0] hard, input logic ace);
      return (ace && hard <= 5'd11) ? hard + ACE_BONUS : hard;
   endfunction
endpackage

// File: rtl/blackjack_hand_scorer_if.sv
// blackjack_hand_scorer_if: card/turn/score signals between draw stage, scorer and display
interface blackjack_hand_scorer_if;
   logic       start;
   logic [3:0] card;
   logic       card_valid;
   logic       stand;
   logic       turn;
   logic       dealer_hit;
   logic [4:0] player_total;
   logic [4:0] dealer_total;
   logic [1:0] result;
   logic       done;
   logic       bad_card;
   modport master (
      output start, card, card_valid, stand,
      input  turn, dealer_hit, player_total, dealer_total, result, done, bad_card
   );
   modport slave (
      input  start, card, card_valid, stand,
      output turn, dealer_hit, player_total, dealer_total, result, done, bad_card
   );
endinterface

// File: rtl/blackjack_hand_scorer_hand_accum.sv
// hand_accum: one hand's hard sum and ace flag, with best total and bust derived from them
module hand_accum
   import blackjack_pkg::*;
#(
   parameter logic [4:0] BUST_LIMIT = 5'd21
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       add,
   input  logic [3:0] card,
   output logic [4:0] hard,
   output logic       ace_seen,
   output logic [4:0] best,
   output logic       bust
);
   // accumulate the card with aces counted as 1; clear starts a fresh hand
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         hard     <= '0;
         ace_seen <= 1'b0;
      end else if (add) begin
         hard     <= hard + {1'b0, card};
         ace_seen <= ace_seen | (card == ACE_VALUE);
      end
   end
   assign best = best_of(hard, ace_seen);
   assign bust = best > BUST_LIMIT;
endmodule

// File: rtl/blackjack_hand_scorer.sv
// blackjack_hand_scorer: turn sequencing FSM and outcome resolution over two hand accumulators
module blackjack_hand_scorer
   import blackjack_pkg::*;
#(
   parameter logic [4:0] BUST_LIMIT   = 5'd21,
   parameter logic [4:0] DEALER_STAND = 5'd17
) (
   input logic                   clock,
   input logic                   reset,
   blackjack_hand_scorer_if.slave bus
);
   state_t     state, state_n;
   result_t    result, result_n;
   logic       clear, good, p_add, d_add, new_bust, bad_card;
   logic [4:0] p_hard, d_hard, p_best, d_best, act_hard;
   logic       p_ace, d_ace, p_bust, d_bust, act_ace;

   hand_accum #(.BUST_LIMIT(BUST_LIMIT)) u_player (
      .clock(clock), .reset(reset), .clear(clear), .add(p_add), .card(bus.card),
      .hard(p_hard), .ace_seen(p_ace), .best(p_best), .bust(p_bust)
   );
   hand_accum #(.BUST_LIMIT(BUST_LIMIT)) u_dealer (
      .clock(clock), .reset(reset), .clear(clear), .add(d_add), .card(bus.card),
      .hard(d_hard), .ace_seen(d_ace), .best(d_best), .bust(d_bust)
   );

   assign good           = bus.card_valid && bus.card != 4'd0 && bus.card <= MAX_CARD;
   assign bus.turn       = state == DEALER;
   assign bus.dealer_hit = state == DEALER && d_best < DEALER_STAND;
   assign bus.done       = state == DONE;
   assign p_add          = state == PLAYER && good;
   assign d_add          = bus.dealer_hit && good;
   assign act_hard       = bus.turn ? d_hard : p_hard;
   assign act_ace        = bus.turn ? d_ace : p_ace;
   // a card arriving with stand must be able to bust before the turn passes
   assign new_bust       = best_of(act_hard + {1'b0, bus.card}, act_ace | (bus.card == ACE_VALUE)) > BUST_LIMIT;
   assign result_n       = p_bust ? RES_DEALER : d_bust ? RES_PLAYER :
                           p_best > d_best ? RES_PLAYER : p_best < d_best ? RES_DEALER : RES_PUSH;
   assign bus.player_total = p_best;
   assign bus.dealer_total = d_best;
   assign bus.result       = result;
   assign bus.bad_card     = bad_card;

   // state register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // next-state and hand-clear decode
   always_comb begin
      state_n = state;
      clear   = 1'b0;
      if (state == IDLE || state == DONE) begin
         clear   = bus.start;
         state_n = bus.start ? PLAYER : state;
      end else if (state == PLAYER) begin
         if (good)           state_n = new_bust ? RESOLVE : bus.stand ? DEALER : PLAYER;
         else if (bus.stand) state_n = DEALER;
      end else if (state == DEALER) begin
         state_n = bus.dealer_hit ? DEALER : RESOLVE;
      end else begin
         state_n = DONE;
      end
   end

   // outcome latched in RESOLVE, illegal cards flagged the cycle after their strobe
   always_ff @(posedge clock) begin
      if (reset) begin
         result   <= RES_NONE;
         bad_card <= 1'b0;
      end else begin
         result   <= clear ? RES_NONE : state == RESOLVE ? result_n : result;
         bad_card <= bus.card_valid && !good;
      end
   end
endmodule

// File: tb/tb_blackjack_hand_scorer.sv
// tb_blackjack_hand_scorer: directed rounds with hand-computed totals and outcomes
module tb_blackjack_hand_scorer;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   blackjack_hand_scorer_if bus ();
   blackjack_hand_scorer dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic deal(input logic [3:0] v, input logic with_stand = 1'b0);
      bus.card       = v;
      bus.card_valid = 1'b1;
      bus.stand      = with_stand;
      tick();
      bus.card_valid = 1'b0;
      bus.stand      = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic pulse_stand();
      bus.stand = 1'b1;
      tick();
      bus.stand = 1'b0;
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.card       = 4'd0;
      bus.card_valid = 1'b0;
      bus.stand      = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_turn", bus.turn, 0);
      chk("rst_hit", bus.dealer_hit, 0);
      chk("rst_ptot", bus.player_total, 0);
      chk("rst_dtot", bus.dealer_total, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_bad", bus.bad_card, 0);
      deal(4'd5);
      chk("idle_ignore", bus.player_total, 0);

      // round 1: player 17 stands, dealer 18 wins
      pulse_start();
      deal(4'd10);
      deal(4'd7);
      chk("r1_ptot", bus.player_total, 17);
      chk("r1_turn0", bus.turn, 0);
      pulse_stand();
      chk("r1_turn1", bus.turn, 1);
      chk("r1_hit1", bus.dealer_hit, 1);
      deal(4'd10);
      chk("r1_hit_at10", bus.dealer_hit, 1);
      deal(4'd8);
      chk("r1_dtot", bus.dealer_total, 18);
      chk("r1_hit0", bus.dealer_hit, 0);
      tick();
      tick();
      chk("r1_result", bus.result, 2);
      chk("r1_done", bus.done, 1);
      chk("r1_ptot_hold", bus.player_total, 17);

      // round 2: soft then hard 17, then bust
      pulse_start();
      chk("r2_clr_result", bus.result, 0);
      chk("r2_clr_done", bus.done, 0);
      chk("r2_clr_ptot", bus.player_total, 0);
      deal(4'd1);
      deal(4'd6);
      chk("r2_soft17", bus.player_total, 17);
      deal(4'd10);
      chk("r2_hard17", bus.player_total, 17);
      deal(4'd9);
      chk("r2_bust_tot", bus.player_total, 26);
      chk("r2_turn_bust", bus.turn, 0);
      tick();
      chk("r2_result", bus.result, 2);
      chk("r2_done", bus.done, 1);
      chk("r2_dtot", bus.dealer_total, 0);
      chk("r2_turn_done", bus.turn, 0);

      // round 3: dealer busts at 26
      pulse_start();
      deal(4'd10);
      deal(4'd9);
      pulse_stand();
      deal(4'd10);
      deal(4'd6);
      chk("r3_hit16", bus.dealer_hit, 1);
      deal(4'd10);
      chk("r3_dtot", bus.dealer_total, 26);
      tick();
      tick();
      chk("r3_result", bus.result, 1);

      // round 4: card with stand, push, late card dropped
      pulse_start();
      deal(4'd10);
      deal(4'd8, 1'b1);
      chk("r4_turn", bus.turn, 1);
      chk("r4_ptot", bus.player_total, 18);
      deal(4'd10);
      deal(4'd8);
      chk("r4_dtot", bus.dealer_total, 18);
      deal(4'd5);
      chk("r4_drop", bus.dealer_total, 18);
      tick();
      chk("r4_result", bus.result, 3);
      chk("r4_done", bus.done, 1);

      // round 5: illegal cards, then reset mid dealer turn
      pulse_start();
      deal(4'd0);
      chk("r5_bad0", bus.bad_card, 1);
      chk("r5_tot0", bus.player_total, 0);
      tick();
      chk("r5_bad_clr", bus.bad_card, 0);
      deal(4'd12);
      chk("r5_bad12", bus.bad_card, 1);
      chk("r5_tot12", bus.player_total, 0);
      deal(4'd5);
      chk("r5_good", bus.bad_card, 0);
      chk("r5_tot5", bus.player_total, 5);
      pulse_stand();
      deal(4'd10);
      deal(4'd2);
      chk("r5_dtot12", bus.dealer_total, 12);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst2_turn", bus.turn, 0);
      chk("rst2_hit", bus.dealer_hit, 0);
      chk("rst2_ptot", bus.player_total, 0);
      chk("rst2_dtot", bus.dealer_total, 0);
      chk("rst2_done", bus.done, 0);
      pulse_start();
      deal(4'd4);
      chk("r6_ptot", bus.player_total, 4);
      chk("r6_dtot", bus.dealer_total, 0);
      chk("r6_turn", bus.turn, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/blackjack_hand_scorer.md
Name: blackjack_hand_scorer

Overview:
- Consumes the 4-bit card values produced by the card-draw stage and accumulates separate player and dealer hands.
- Tracks aces as soft (11) or hard (1) and detects busts.
- Runs the turn sequence: player, then dealer, then resolve.
- Drives the turn select back to the draw stage and presents totals and outcome to the display/HEX logic.

Parameters:
- BUST_LIMIT, 21, highest non-bust total.
- DEALER_STAND, 17, dealer stops drawing when its best total is >= this value (soft 17 stands).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- start  in  1  one-cycle pulse; begins a new round from IDLE or DONE.
- card  in  4  card value; 1 = ace, 2..10 = face value.
- card_valid  in  1  one-cycle strobe; card is valid this cycle.
- stand  in  1  one-cycle pulse; player ends their turn.
- turn  out  1  0 = player, 1 = dealer; feeds the draw stage turn input.
- dealer_hit  out  1  high in DEALER while dealer best total < DEALER_STAND.
- player_total  out  5  player best total.
- dealer_total  out  5  dealer best total.
- result  out  2  00 none, 01 player wins, 10 dealer wins, 11 push.
- done  out  1  high while in DONE.
- bad_card  out  1  one-cycle pulse when card_valid arrives with card = 0 or card > 10.

Behaviour:
- Reset: state = IDLE, turn = 0, dealer_hit = 0, totals = 0, ace flags = 0, result = 00, done = 0, bad_card = 0. Reset mid-round abandons the hand immediately.
- Per hand, store a 5-bit hard sum (aces count 1) and an ace_seen flag.
- Best total = hard + 10 when ace_seen and hard <= 11; otherwise best total = hard.
- Hard sum never exceeds 30: the stage leaves the accepting state on bust, so no wrap is possible.
- Card latency: the totals and the bust check reflect a card on the cycle after its card_valid.
- IDLE: ignores card_valid and stand. On start: clear both hands and result, then go to PLAYER.
- PLAYER (turn = 0):
  - A valid card adds to the player hand.
  - If the new best total > BUST_LIMIT, go to RESOLVE.
  - Otherwise, stand moves to DEALER.
  - card_valid and stand in the same cycle: the card is added first. Bust takes priority; if no bust, go to DEALER.
- DEALER (turn = 1):
  - dealer_hit = (best < DEALER_STAND), combinational from registered totals.
  - A valid card adds to the dealer hand only while dealer_hit = 1. Any card arriving with dealer_hit = 0 is dropped.
  - When best >= DEALER_STAND, go to RESOLVE; this includes bust.
  - stand is ignored.
- RESOLVE (1 cycle), evaluated in order:
  - player bust -> 10.
  - else dealer bust -> 01.
  - else player > dealer -> 01.
  - else player < dealer -> 10.
  - else -> 11.
  - The result is registered, then the state moves to DONE.
- DONE: done = 1. Result and totals hold until start, which behaves as in IDLE. card_valid and stand are ignored.
- bad_card: asserted in any state when card_valid arrives with an illegal value. The card is never added.
- start in PLAYER or DEALER is ignored; only reset aborts a round.

Decomposition:
- Shared package blackjack_pkg holds:
  - state encoding: IDLE, PLAYER, DEALER, RESOLVE, DONE.
  - result codes: RES_NONE, RES_PLAYER, RES_DEALER, RES_PUSH.
  - constants ACE_VALUE = 1, ACE_BONUS = 10, MAX_CARD = 10.
- One sub-module, hand_accum, instantiated twice (player, dealer):
  - inputs: clock, reset, clear, add, card.
  - outputs: hard sum, ace_seen, best total, bust flag.
- The top level holds the FSM and result logic only.

Test Plan:
- start; player cards 10, 7; stand; dealer cards 10, 8 -> player_total = 17, dealer_total = 18, dealer_hit drops after the 8, result = 10, done = 1.
- start; player ace, 6 -> player_total = 17 (soft); add 10 -> player_total = 17 (hard); add 9 -> bust, result = 10, dealer hand stays 0, turn never goes to 1.
- start; player 10, 9, stand; dealer 10, 6, 10 -> dealer bust at 26, result = 01.
- start; player 10, 8 with stand asserted on the same cycle as the 8 -> state goes to DEALER with player_total = 18. Dealer 10, 8 -> result = 11. A 5 pulsed after dealer reaches 18 is dropped, dealer_total stays 18.
- card_valid with card = 0 and with card = 12 during PLAYER -> bad_card pulses each time, player_total unchanged.
- reset asserted in DEALER with dealer_total = 12 -> next cycle state = IDLE, all outputs at reset values; start then begins a clean round.
